three_bit_comparator: RTL and testbench

THREE_BIT_COMPARATOR -- requirements
Module: three_bit_comparator

---
 rtl/three_bit_comparator.sv | 105 ++++++++++
 tb/tb_three_bit_comparator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/three_bit_comparator.sv
// rtl/three_bit_comparator.sv - registered magnitude comparator with optional result statistics
//
// Purpose: samples A and B when in_valid is high and registers a one-hot
// GT/LT/EQ result one cycle later, flagged by out_valid. Signed or unsigned
// compare is chosen by SIGNED.
//
// Optional feature macro: THREE_BIT_COMPARATOR_STATS_EN
//   defined   -> adds clr_cnt input and saturating gt_cnt/lt_cnt/eq_cnt outputs
//   undefined -> those ports and the counter logic are absent
//
// Parameters:
//   WIDTH  operand width, 1..32
//   SIGNED 0 = unsigned compare, 1 = two's-complement compare
//   CNT_W  width of each statistics counter
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   A/B are sampled this cycle
//   A, B       operands
//   GT, LT, EQ registered one-hot result
//   out_valid  result was updated by the previous cycle's sample
//   clr_cnt    synchronous counter clear (stats build only)
//   gt_cnt, lt_cnt, eq_cnt  result counters (stats build only)

module three_bit_comparator #(
  parameter int WIDTH  = 3,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             GT,
  output logic             LT,
  output logic             EQ,
`ifdef THREE_BIT_COMPARATOR_STATS_EN
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
`endif
  output logic             out_valid
);

  logic gt_c;
  logic lt_c;
  logic eq_c;

  // Compare on the raw operands; the signed branch reinterprets the MSB as sign.
  always_comb begin
    gt_c = 1'b0;
    lt_c = 1'b0;
    eq_c = (A == B);
    if (SIGNED != 0) begin
      gt_c = ($signed(A) > $signed(B));
      lt_c = ($signed(A) < $signed(B));
    end else begin
      gt_c = (A > B);
      lt_c = (A < B);
    end
  end

  // Reset value is the result for A == B == 0 so the outputs stay one-hot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      GT        <= 1'b0;
      LT        <= 1'b0;
      EQ        <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        GT <= gt_c;
        LT <= lt_c;
        EQ <= eq_c;
      end
    end
  end

`ifdef THREE_BIT_COMPARATOR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Clear has priority over a coincident sample; counters saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_cnt <= '0;
      lt_cnt <= '0;
      eq_cnt <= '0;
    end else if (clr_cnt) begin
      gt_cnt <= '0;
      lt_cnt <= '0;
      eq_cnt <= '0;
    end else if (in_valid) begin
      if (gt_c && (gt_cnt != CNT_MAX)) gt_cnt <= gt_cnt + CNT_ONE;
      if (lt_c && (lt_cnt != CNT_MAX)) lt_cnt <= lt_cnt + CNT_ONE;
      if (eq_c && (eq_cnt != CNT_MAX)) eq_cnt <= eq_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_three_bit_comparator.sv
// tb/tb_three_bit_comparator.sv - scoreboard bench for three_bit_comparator (unsigned and signed instances)

module tb_three_bit_comparator;

  logic       clk;
  logic       rst_n;

  logic       u_valid;
  logic [2:0] u_a;
  logic [2:0] u_b;
  logic       u_gt, u_lt, u_eq, u_ov;

  logic       s_valid;
  logic [2:0] s_a;
  logic [2:0] s_b;
  logic       s_gt, s_lt, s_eq, s_ov;

`ifdef THREE_BIT_COMPARATOR_STATS_EN
  logic       clr_cnt;
  logic [1:0] gt_cnt, lt_cnt, eq_cnt;
  logic [7:0] s_gt_cnt, s_lt_cnt, s_eq_cnt;
  logic       s_clr;
`endif

  int errors = 0;
  int checks = 0;

  logic [2:0] q_u[$];   // expected {GT,LT,EQ} for unsigned instance
  logic [2:0] q_s[$];   // expected {GT,LT,EQ} for signed instance

  three_bit_comparator #(.WIDTH(3), .SIGNED(0), .CNT_W(2)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(u_valid), .A(u_a), .B(u_b),
    .GT(u_gt), .LT(u_lt), .EQ(u_eq),
`ifdef THREE_BIT_COMPARATOR_STATS_EN
    .clr_cnt(clr_cnt), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt),
`endif
    .out_valid(u_ov)
  );

  three_bit_comparator #(.WIDTH(3), .SIGNED(1), .CNT_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .A(s_a), .B(s_b),
    .GT(s_gt), .LT(s_lt), .EQ(s_eq),
`ifdef THREE_BIT_COMPARATOR_STATS_EN
    .clr_cnt(s_clr), .gt_cnt(s_gt_cnt), .lt_cnt(s_lt_cnt), .eq_cnt(s_eq_cnt),
`endif
    .out_valid(s_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitors: pop an expectation whenever a DUT presents a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_ov) begin
        if (q_u.size() == 0) check("u_unexpected_out_valid", 32'd1, 32'd0);
        else check("u_result", {29'd0, u_gt, u_lt, u_eq}, {29'd0, q_u.pop_front()});
      end
      if (s_ov) begin
        if (q_s.size() == 0) check("s_unexpected_out_valid", 32'd1, 32'd0);
        else check("s_result", {29'd0, s_gt, s_lt, s_eq}, {29'd0, q_s.pop_front()});
      end
      check("u_onehot", {31'd0, $onehot({u_gt, u_lt, u_eq})}, 32'd1);
      check("s_onehot", {31'd0, $onehot({s_gt, s_lt, s_eq})}, 32'd1);
    end
  end

  task automatic issue_u(input logic [2:0] a, input logic [2:0] b, input logic [2:0] exp);
    @(posedge clk); #1;
    u_a = a; u_b = b; u_valid = 1'b1;
    q_u.push_back(exp);
  endtask

  task automatic issue_s(input logic [2:0] a, input logic [2:0] b, input logic [2:0] exp);
    @(posedge clk); #1;
    s_a = a; s_b = b; s_valid = 1'b1;
    q_s.push_back(exp);
  endtask

  task automatic idle;
    @(posedge clk); #1;
    u_valid = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    u_valid = 1'b0; u_a = '0; u_b = '0;
    s_valid = 1'b0; s_a = '0; s_b = '0;
`ifdef THREE_BIT_COMPARATOR_STATS_EN
    clr_cnt = 1'b0; s_clr = 1'b0;
`endif

    // Reset state
    #12;
    check("rst_gt", {31'd0, u_gt}, 32'd0);
    check("rst_lt", {31'd0, u_lt}, 32'd0);
    check("rst_eq", {31'd0, u_eq}, 32'd1);
    check("rst_ov", {31'd0, u_ov}, 32'd0);
    check("rst_s_eq", {31'd0, s_eq}, 32'd1);
    #1 rst_n = 1'b1;

    // Exhaustive unsigned, back-to-back
    for (int i = 0; i < 64; i++) begin
      logic [2:0] a, b;
      a = i[5:3]; b = i[2:0];
      issue_u(a, b, {a > b, a < b, a == b});
    end
    idle();
    idle();
    check("exhaustive_drained", q_u.size(), 32'd0);

    // Signed directed vectors
    issue_s(3'b100, 3'b011, 3'b010);
    issue_s(3'b111, 3'b110, 3'b100);
    issue_s(3'b101, 3'b101, 3'b001);
    issue_s(3'b011, 3'b111, 3'b100);
    issue_s(3'b000, 3'b100, 3'b100);
    idle();
    idle();
    check("signed_drained", q_s.size(), 32'd0);

    // Hold: one valid GT sample, then changed operands without in_valid
    issue_u(3'd6, 3'd2, 3'b100);
    @(posedge clk); #1;
    u_a = 3'd1; u_b = 3'd4; u_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_gt", {31'd0, u_gt}, 32'd1);
      check("hold_ov", {31'd0, u_ov}, 32'd0);
    end

`ifdef THREE_BIT_COMPARATOR_STATS_EN
    // Counters, CNT_W=2
    @(posedge clk); #1; clr_cnt = 1'b1;
    @(posedge clk); #1; clr_cnt = 1'b0;
    for (int k = 0; k < 5; k++) issue_u(3'd5, 3'd1, 3'b100);
    idle();
    #1;
    check("cnt_gt_sat", {30'd0, gt_cnt}, 32'd3);
    check("cnt_lt", {30'd0, lt_cnt}, 32'd0);
    check("cnt_eq", {30'd0, eq_cnt}, 32'd0);
    issue_u(3'd2, 3'd2, 3'b001);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0; u_valid = 1'b0;
    check("clr_gt", {30'd0, gt_cnt}, 32'd0);
    check("clr_lt", {30'd0, lt_cnt}, 32'd0);
    check("clr_eq", {30'd0, eq_cnt}, 32'd0);
    check("clr_eq_out", {31'd0, u_eq}, 32'd1);
    idle();
`endif

    // Mid-stream asynchronous reset
    issue_u(3'd2, 3'd5, 3'b010);
    idle();
    @(negedge clk);
    #1;
    u_a = 3'd7; u_b = 3'd0; u_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("arst_gt", {31'd0, u_gt}, 32'd0);
    check("arst_lt", {31'd0, u_lt}, 32'd0);
    check("arst_eq", {31'd0, u_eq}, 32'd1);
    check("arst_ov", {31'd0, u_ov}, 32'd0);
    @(posedge clk); #1;
    check("arst_discard_ov", {31'd0, u_ov}, 32'd0);
    check("arst_discard_eq", {31'd0, u_eq}, 32'd1);
    #1;
    q_u.push_back(3'b100);
    rst_n = 1'b1;
    idle();
    idle();
    idle();
    check("final_u_drained", q_u.size(), 32'd0);
    check("final_s_drained", q_s.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
